sec_timer_ctrl: RTL and testbench
=================================

Name: sec_timer_ctrl

Overview:
Stopwatch/countdown controller built around a 1-second tick prescaler and BCD minute:second counters (00:00-99:59). It sequences the prescaler and counters from start/stop/clear/load commands, supports up-count or down-count, and flags expiry. It sits between the push-button/command logic and the seven-segment display digit drivers.

Parameters:
CLK_DIV, 24000000, clk cycles per 1-second tick (24 MHz board clock); must be >= 2
DIV_W, 25, prescaler counter width; must satisfy 2**DIV_W >= CLK_DIV

Ports:
clk  input  1  system clock
res  input  1  synchronous reset, active-high
start  input  1  level command: begin/resume counting
stop  input  1  level command: pause counting
clear  input  1  level command: return to IDLE, time 00:00
load  input  1  level command: load preset time
mode  input  1  0 = count up, 1 = count down; sampled on start
preset_min  input  8  BCD minutes preset, {tens, ones}
preset_sec  input  8  BCD seconds preset, {tens, ones}
min_bcd  output  8  current minutes, BCD
sec_bcd  output  8  current seconds, BCD
tick  output  1  one-cycle pulse, coincident with each time update
running  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Interface: one clock, clk; reset res is synchronous and active-high.
- Reset (res=1 at a clk edge): state IDLE, prescaler 0, mode_q 0, min_bcd 00, sec_bcd 00, tick 0, running 0, done 0. res overrides every command.
- All outputs are registered.
- States:
  - IDLE: cleared, or preset loaded.
  - RUN: prescaler active.
  - PAUSE: stopped; prescaler value is held.
  - DONE: down-count expired.
- Command priority, evaluated each cycle: clear > load > stop > start.
  - clear: any state -> IDLE. Time 00:00, prescaler 0, done 0.
  - load: accepted in IDLE, PAUSE and DONE; ignored in RUN. Time <= clamped preset, prescaler 0, next state IDLE.
  - Clamp rule: sec tens >5 -> 5; every other digit >9 -> 9.
  - stop: RUN -> PAUSE. Ignored in all other states.
  - start: IDLE or PAUSE -> RUN, and mode_q <= mode. Ignored in RUN and DONE.
  - Down-mode start at 00:00: go directly to DONE; done=1 on the following cycle.
- Prescaler: counts only in RUN. At each edge where prescaler == CLK_DIV-1:
  - prescaler <= 0;
  - tick <= 1;
  - time update on that same edge.
  - At all other times tick <= 0.
- PAUSE -> RUN resumes the partial second; the prescaler is not reset.
- First tick after start from IDLE occurs CLK_DIV cycles after the start edge.
- Up count:
  - sec_bcd ones 9 -> 0 carries to tens.
  - sec_bcd 59 -> 00 carries to min_bcd.
  - min_bcd 99:59 -> 00:00 wraps and counting continues (unless the optional feature is enabled).
- Down count:
  - sec_bcd 00 -> 59 with a borrow from min_bcd.
  - On the tick that reaches 00:00: state -> DONE, done=1, running=0. Time holds at 00:00.
- mode changes during RUN or PAUSE have no effect until the next start from IDLE or PAUSE.
- stop and tick on the same edge: the tick update completes on that edge, then the state becomes PAUSE.
- Commands are levels. A held start in RUN has no further effect. A held start in PAUSE with stop also high: stop wins, state stays PAUSE.

Optional Feature:
Macro SEC_TIMER_SAT_EN.
- Defined: in up mode, the tick that would advance past 99:59 instead holds 99:59, enters DONE and sets done=1.
- Undefined: up mode wraps 99:59 -> 00:00 and remains in RUN; done is never set in up mode.

Test Plan:
(All with CLK_DIV=4.)
1. res=1 for 2 cycles, then start=1 for 1 cycle with mode=0 -> running=1. tick pulses every 4 cycles. sec_bcd after 10 ticks = 0x10; after 60 ticks min_bcd=0x01, sec_bcd=0x00.
2. load with preset 0x00:0x03, then start with mode=1 -> sec_bcd 02, 01, 00 on successive ticks. On the 00 tick: done=1, running=0. Further start is ignored.
3. Up count; assert stop 2 cycles after a tick; wait 20 cycles; start -> no tick while paused. First tick arrives 2 cycles after resume. Value unchanged across the pause.
4. load preset 0x7A:0x6F -> min_bcd=0x79, sec_bcd=0x59. load asserted during RUN -> ignored, counting continues.
5. clear, load and start asserted together during RUN -> clear wins: IDLE, 00:00, done=0. Separately, res=1 mid-RUN -> all outputs 0 on the next edge.
6. Preset 99:58, up count: without the macro -> 99:59 then 00:00, running stays 1. With SEC_TIMER_SAT_EN -> 99:59, then done=1 and time holds 99:59.

Source files
------------

// File: rtl/sec_timer_ctrl.sv
// rtl/sec_timer_ctrl.sv - 1 s prescaler plus BCD MM:SS up/down stopwatch FSM
// Optional SEC_TIMER_SAT_EN: up count saturates at 99:59 and enters DONE instead of wrapping.
module sec_timer_ctrl #(
  parameter int CLK_DIV = 24000000,
  parameter int DIV_W   = 25
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic       mode,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_presc;
  logic             r_mode;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic             r_tick;
  logic             r_running;
  logic             r_done;

  logic [7:0] w_up_min, w_up_sec, w_dn_min, w_dn_sec;
  logic [7:0] w_pre_min, w_pre_sec;
  logic       w_presc_end, w_dn_zero, w_is_zero, w_at_max;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign w_pre_min   = {clamp_digit(preset_min[7:4], 4'd9), clamp_digit(preset_min[3:0], 4'd9)};
  assign w_pre_sec   = {clamp_digit(preset_sec[7:4], 4'd5), clamp_digit(preset_sec[3:0], 4'd9)};
  assign w_presc_end = (r_presc == DIV_W'(CLK_DIV - 1));
  assign w_is_zero   = (r_min == 8'h00) && (r_sec == 8'h00);
  assign w_at_max    = (r_min == 8'h99) && (r_sec == 8'h59);
  assign w_dn_zero   = (w_dn_min == 8'h00) && (w_dn_sec == 8'h00);

  // Digit-wise carry chain; 99:59 naturally rolls to 00:00.
  always_comb begin
    w_up_min = r_min;
    w_up_sec = r_sec;
    if (r_sec[3:0] != 4'd9) begin
      w_up_sec[3:0] = r_sec[3:0] + 4'd1;
    end else begin
      w_up_sec[3:0] = 4'd0;
      if (r_sec[7:4] != 4'd5) begin
        w_up_sec[7:4] = r_sec[7:4] + 4'd1;
      end else begin
        w_up_sec[7:4] = 4'd0;
        if (r_min[3:0] != 4'd9) begin
          w_up_min[3:0] = r_min[3:0] + 4'd1;
        end else begin
          w_up_min[3:0] = 4'd0;
          w_up_min[7:4] = (r_min[7:4] != 4'd9) ? r_min[7:4] + 4'd1 : 4'd0;
        end
      end
    end
  end

  always_comb begin
    w_dn_min = r_min;
    w_dn_sec = r_sec;
    if (r_sec[3:0] != 4'd0) begin
      w_dn_sec[3:0] = r_sec[3:0] - 4'd1;
    end else begin
      w_dn_sec[3:0] = 4'd9;
      if (r_sec[7:4] != 4'd0) begin
        w_dn_sec[7:4] = r_sec[7:4] - 4'd1;
      end else begin
        w_dn_sec[7:4] = 4'd5;
        if (r_min[3:0] != 4'd0) begin
          w_dn_min[3:0] = r_min[3:0] - 4'd1;
        end else begin
          w_dn_min[3:0] = 4'd9;
          w_dn_min[7:4] = (r_min[7:4] != 4'd0) ? r_min[7:4] - 4'd1 : 4'd9;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_mode    <= 1'b0;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (clear) begin
        r_state   <= S_IDLE;
        r_presc   <= '0;
        r_min     <= 8'h00;
        r_sec     <= 8'h00;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else if (load && (r_state != S_RUN)) begin
        r_state   <= S_IDLE;
        r_presc   <= '0;
        r_min     <= w_pre_min;
        r_sec     <= w_pre_sec;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_presc_end) begin
              r_presc <= '0;
              r_tick  <= 1'b1;
              if (r_mode) begin
                r_min <= w_dn_min;
                r_sec <= w_dn_sec;
                if (w_dn_zero) begin
                  r_state   <= S_DONE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
                end else if (stop) begin
                  r_state   <= S_PAUSE;
                  r_running <= 1'b0;
                end
              end
`ifdef SEC_TIMER_SAT_EN
              else if (w_at_max) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
`endif
              else begin
                r_min <= w_up_min;
                r_sec <= w_up_sec;
                if (stop) begin
                  r_state   <= S_PAUSE;
                  r_running <= 1'b0;
                end
              end
            end else begin
              r_presc <= r_presc + DIV_W'(1);
              if (stop) begin
                r_state   <= S_PAUSE;
                r_running <= 1'b0;
              end
            end
          end
          // stop only has meaning in RUN/PAUSE, so it blocks start only when paused.
          S_IDLE, S_PAUSE: begin
            if (start && !(stop && (r_state == S_PAUSE))) begin
              r_mode <= mode;
              if (mode && w_is_zero) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_RUN;
                r_running <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
  assign tick    = r_tick;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// tb/tb_sec_timer_ctrl.sv - scoreboard bench for sec_timer_ctrl at CLK_DIV=4
module tb_sec_timer_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       res, start, stop, clear, load, mode;
  logic [7:0] preset_min, preset_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       tick, running, done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  int          n_ticks;

  always #5 clk = ~clk;

  sec_timer_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
    .clk(clk), .res(res), .start(start), .stop(stop), .clear(clear), .load(load),
    .mode(mode), .preset_min(preset_min), .preset_sec(preset_sec),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .tick(tick), .running(running), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_time(input int s);
    int m, sc;
    m  = (s / 60) % 100;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // Wait for the next tick, check its distance in cycles, then score the displayed time.
  task automatic wait_tick(input string tag, input int exp_gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 50);
    chk({tag, "_gap"}, n, exp_gap);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else chk(tag, {min_bcd, sec_bcd}, sb_q.pop_front());
  endtask

  task automatic cmd(input logic c_start, input logic c_stop, input logic c_clear,
                     input logic c_load, input logic c_mode);
    start = c_start; stop = c_stop; clear = c_clear; load = c_load; mode = c_mode;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  task automatic idle_cycles(input int n, output int t);
    t = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tick) t++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; mode = 1'b0;
    preset_min = 8'h00; preset_sec = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {min_bcd, sec_bcd, tick, running, done}, 19'h0);
    res = 1'b0;

    // Up count from 00:00
    cmd(1, 0, 0, 0, 0);
    chk("t1_run", running, 1);
    for (int i = 1; i <= 60; i++) sb_q.push_back(to_time(i));
    for (int i = 1; i <= 60; i++) begin
      wait_tick("t1", CLK_DIV);
      if (i == 10) chk("t1_sec10", sec_bcd, 8'h10);
    end
    chk("t1_min1", {min_bcd, sec_bcd}, 16'h0100);

    // Down count to expiry
    cmd(0, 0, 1, 0, 0);
    chk("t2_clear", {min_bcd, sec_bcd, running, done}, 18'h0);
    preset_min = 8'h00; preset_sec = 8'h03;
    cmd(0, 0, 0, 1, 0);
    chk("t2_load", {min_bcd, sec_bcd}, 16'h0003);
    cmd(1, 0, 0, 0, 1);
    for (int i = 2; i >= 0; i--) sb_q.push_back(to_time(i));
    for (int i = 0; i < 3; i++) wait_tick("t2", CLK_DIV);
    chk("t2_done", {done, running}, 2'b10);
    cmd(1, 0, 0, 0, 1);
    idle_cycles(10, n_ticks);
    chk("t2_hold_ticks", n_ticks, 0);
    chk("t2_hold", {min_bcd, sec_bcd, done, running}, {16'h0000, 2'b10});

    // Clamped preset, then load ignored in RUN
    preset_min = 8'h7A; preset_sec = 8'h6F;
    cmd(0, 0, 0, 1, 0);
    chk("t4_clamp", {min_bcd, sec_bcd, done}, {16'h7959, 1'b0});
    cmd(1, 0, 0, 0, 0);
    sb_q.push_back(16'h8000);
    wait_tick("t4", CLK_DIV);
    preset_min = 8'h00; preset_sec = 8'h00;
    sb_q.push_back(16'h8001);
    cmd(0, 0, 0, 1, 0);
    wait_tick("t4_ld", CLK_DIV - 1);
    chk("t4_run", running, 1);

    // Pause two cycles after a tick, resume the partial second
    @(negedge clk);
    cmd(0, 1, 0, 0, 0);
    chk("t3_pause", running, 0);
    idle_cycles(20, n_ticks);
    chk("t3_no_tick", n_ticks, 0);
    chk("t3_held", {min_bcd, sec_bcd}, 16'h8001);
    cmd(1, 0, 0, 0, 0);
    mode = 1'b1;
    sb_q.push_back(16'h8002);
    wait_tick("t3_resume", 2);
    sb_q.push_back(16'h8003);
    wait_tick("t3_mode", CLK_DIV);
    mode = 1'b0;

    // clear beats load/start; down start at 00:00; reset mid-run
    preset_min = 8'h12; preset_sec = 8'h34;
    cmd(1, 0, 1, 1, 0);
    chk("t5_clear", {min_bcd, sec_bcd, tick, running, done}, 19'h0);
    cmd(1, 0, 0, 0, 1);
    chk("t5_dn0", {done, running}, 2'b10);
    preset_min = 8'h00; preset_sec = 8'h05;
    cmd(0, 0, 0, 1, 0);
    chk("t5_load", {min_bcd, sec_bcd, done}, {16'h0005, 1'b0});
    cmd(1, 0, 0, 0, 0);
    sb_q.push_back(16'h0006);
    wait_tick("t5", CLK_DIV);
    res = 1'b1;
    @(negedge clk);
    chk("t5_res", {min_bcd, sec_bcd, tick, running, done}, 19'h0);
    res = 1'b0;

    // Top of range: wrap or saturate
    preset_min = 8'hFC; preset_sec = 8'h58;
    cmd(0, 0, 0, 1, 0);
    chk("t6_load", {min_bcd, sec_bcd}, 16'h9958);
    cmd(1, 0, 0, 0, 0);
    sb_q.push_back(16'h9959);
    wait_tick("t6_a", CLK_DIV);
`ifdef SEC_TIMER_SAT_EN
    sb_q.push_back(16'h9959);
    wait_tick("t6_sat", CLK_DIV);
    chk("t6_sat_done", {done, running}, 2'b10);
    idle_cycles(8, n_ticks);
    chk("t6_sat_ticks", n_ticks, 0);
    chk("t6_sat_hold", {min_bcd, sec_bcd}, 16'h9959);
`else
    sb_q.push_back(16'h0000);
    wait_tick("t6_wrap", CLK_DIV);
    chk("t6_wrap_run", {done, running}, 2'b01);
    sb_q.push_back(16'h0001);
    wait_tick("t6_after", CLK_DIV);
`endif
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
